// File: rtl/free_list_ctrl.sv
// Physical-register free list for a 2-wide rename stage: circular FIFO of free tags
// with two-wide allocate at the head and two-wide release at the tail.
module free_list_ctrl #(
    parameter int unsigned NUM_PHY_REGS  = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned PHY_REG_SEL   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_req_1,
    input  logic                   alloc_req_2,
    output logic                   alloc_ready,
    output logic [PHY_REG_SEL-1:0] phy_dst_1_from_free_list,
    output logic [PHY_REG_SEL-1:0] phy_dst_2_from_free_list,
    input  logic                   free_valid_1,
    input  logic [PHY_REG_SEL-1:0] free_phy_1,
    input  logic                   free_valid_2,
    input  logic [PHY_REG_SEL-1:0] free_phy_2,
    output logic [PHY_REG_SEL:0]   free_count,
    output logic                   overflow_err
);

    localparam int unsigned CNT_W    = PHY_REG_SEL + 1;
    localparam int unsigned SUM_W    = CNT_W + 1;
    localparam int unsigned INIT_CNT = NUM_PHY_REGS - NUM_ARCH_REGS;

    logic [PHY_REG_SEL-1:0] entry_q [NUM_PHY_REGS];
    logic [PHY_REG_SEL-1:0] head_q;
    logic [PHY_REG_SEL-1:0] tail_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;

    logic [1:0]             need_c;
    logic [1:0]             nfree_c;
    logic                   grant_c;
    logic                   drop_c;
    logic                   do_free_c;
    logic [PHY_REG_SEL-1:0] head_p1_c;
    logic [PHY_REG_SEL-1:0] tail_wr2_c;
    logic [CNT_W-1:0]       count_next_c;

    // Demand/release sizing, grant decision and zero-latency tag presentation.
    always_comb begin
        need_c       = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        nfree_c      = {1'b0, free_valid_1} + {1'b0, free_valid_2};
        alloc_ready  = (count_q >= CNT_W'(need_c));
        grant_c      = alloc_ready && (need_c != 2'd0);
        head_p1_c    = head_q + PHY_REG_SEL'(1);
        tail_wr2_c   = free_valid_1 ? (tail_q + PHY_REG_SEL'(1)) : tail_q;
        drop_c       = ({1'b0, count_q} + SUM_W'(nfree_c)) > SUM_W'(NUM_PHY_REGS);
        do_free_c    = !drop_c && (nfree_c != 2'd0);
        count_next_c = count_q;

        phy_dst_1_from_free_list = '0;
        phy_dst_2_from_free_list = '0;
        if (alloc_ready && alloc_req_1) begin
            phy_dst_1_from_free_list = entry_q[head_q];
        end
        // A lone slot-2 request is compacted onto the head entry.
        if (alloc_ready && alloc_req_2) begin
            phy_dst_2_from_free_list = alloc_req_1 ? entry_q[head_p1_c] : entry_q[head_q];
        end

        if (grant_c) begin
            count_next_c = count_next_c - CNT_W'(need_c);
        end
        if (do_free_c) begin
            count_next_c = count_next_c + CNT_W'(nfree_c);
        end
    end

    // Pointer, counter, storage and sticky error state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_PHY_REGS); i++) begin
                if (i < int'(INIT_CNT)) begin
                    entry_q[i] <= PHY_REG_SEL'(NUM_ARCH_REGS + 32'(i));
                end else begin
                    entry_q[i] <= '0;
                end
            end
            head_q     <= '0;
            tail_q     <= PHY_REG_SEL'(INIT_CNT);
            count_q    <= CNT_W'(INIT_CNT);
            overflow_q <= 1'b0;
        end else begin
            if (grant_c) begin
                head_q <= head_q + PHY_REG_SEL'(need_c);
            end
            if (do_free_c) begin
                if (free_valid_1) begin
                    entry_q[tail_q] <= free_phy_1;
                end
                if (free_valid_2) begin
                    entry_q[tail_wr2_c] <= free_phy_2;
                end
                tail_q <= tail_q + PHY_REG_SEL'(nfree_c);
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_next_c;
        end
    end

    assign free_count   = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios plus random traffic
// compared against a queue-based model of the free list.
module tb_free_list_ctrl;

    localparam int NPR = 64;
    localparam int NAR = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_1, alloc_req_2;
    logic       alloc_ready;
    logic [5:0] phy_dst_1_from_free_list, phy_dst_2_from_free_list;
    logic       free_valid_1, free_valid_2;
    logic [5:0] free_phy_1, free_phy_2;
    logic [6:0] free_count;
    logic       overflow_err;

    free_list_ctrl dut (
        .clk                      (clk),
        .reset                    (reset),
        .alloc_req_1              (alloc_req_1),
        .alloc_req_2              (alloc_req_2),
        .alloc_ready              (alloc_ready),
        .phy_dst_1_from_free_list (phy_dst_1_from_free_list),
        .phy_dst_2_from_free_list (phy_dst_2_from_free_list),
        .free_valid_1             (free_valid_1),
        .free_phy_1               (free_phy_1),
        .free_valid_2             (free_valid_2),
        .free_phy_2               (free_phy_2),
        .free_count               (free_count),
        .overflow_err             (overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: list contents in allocation order, plus the sticky error.
    int q[$];
    bit m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = NAR; i < NPR; i++) q.push_back(i);
        m_ovf = 1'b0;
    endtask

    // Reset cycle with junk on the request inputs, which must be ignored.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        alloc_req_1  = 1'($urandom);
        alloc_req_2  = 1'($urandom);
        free_valid_1 = 1'($urandom);
        free_valid_2 = 1'($urandom);
        free_phy_1   = 6'($urandom);
        free_phy_2   = 6'($urandom);
        model_reset();
    endtask

    // One cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input logic a1, input logic a2,
                        input logic v1, input logic [5:0] f1,
                        input logic v2, input logic [5:0] f2);
        int need, nfree, e1, e2;
        bit rdy;
        @(negedge clk);
        reset        = 1'b1;
        alloc_req_1  = a1;
        alloc_req_2  = a2;
        free_valid_1 = v1;
        free_phy_1   = f1;
        free_valid_2 = v2;
        free_phy_2   = f2;
        #1;
        need  = int'(a1) + int'(a2);
        nfree = int'(v1) + int'(v2);
        rdy   = (q.size() >= need);
        e1    = (rdy && a1) ? q[0] : 0;
        e2    = (rdy && a2) ? (a1 ? q[1] : q[0]) : 0;
        check("alloc_ready", int'(alloc_ready), int'(rdy));
        check("phy_dst_1", int'(phy_dst_1_from_free_list), e1);
        check("phy_dst_2", int'(phy_dst_2_from_free_list), e2);
        check("free_count", int'(free_count), q.size());
        check("overflow_err", int'(overflow_err), int'(m_ovf));
        if (q.size() + nfree > NPR) begin
            m_ovf = 1'b1;
            if (rdy) for (int i = 0; i < need; i++) void'(q.pop_front());
        end else begin
            if (rdy) for (int i = 0; i < need; i++) void'(q.pop_front());
            if (v1) q.push_back(int'(f1));
            if (v2) q.push_back(int'(f2));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    initial begin
        reset = 1'b0;
        alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
        free_valid_1 = 1'b0; free_valid_2 = 1'b0;
        free_phy_1 = '0; free_phy_2 = '0;
        model_reset();

        // Dual allocation straight out of reset.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        check("first_pair_1", int'(phy_dst_1_from_free_list), 32);
        check("first_pair_2", int'(phy_dst_2_from_free_list), 33);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        check("second_pair_1", int'(phy_dst_1_from_free_list), 34);
        check("count_after_one", int'(free_count), 30);

        // Lone slot-2 request compacts onto the head.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        check("compact_slot2", int'(phy_dst_2_from_free_list), 32);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        check("after_compact", int'(phy_dst_1_from_free_list), 33);

        // Drain to one entry, refuse a pair, grant a single, then empty.
        do_reset();
        repeat (15) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        check("short_not_ready", int'(alloc_ready), 0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        check("last_tag", int'(phy_dst_1_from_free_list), 63);
        // Tag freed while empty is not usable in the same cycle.
        step(1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0);
        check("empty_not_ready", int'(alloc_ready), 0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        check("bypass_next", int'(phy_dst_1_from_free_list), 5);

        // Fill to 64, then an extra release is dropped and flagged.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 1'b1, 6'(2 * i), 1'b1, 6'(2 * i + 1));
        step(1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 6'd0);
        check("full_count", int'(free_count), 64);
        step(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 6'd10);
        check("ovf_sticky", int'(overflow_err), 1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);

        // Steady 2-in/2-out traffic wraps both pointers.
        do_reset();
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 1'b1, 6'($urandom), 1'b1, 6'($urandom));
        check("wrap_count", int'(free_count), 32);

        // Random traffic biased by occupancy, with occasional mid-run resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int sz, pa, pf;
            sz = q.size();
            pa = (sz < 8) ? 30 : 60;
            pf = (sz > 56) ? 20 : ((sz < 8) ? 75 : 50);
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                step(1'($urandom_range(99) < pa), 1'($urandom_range(99) < pa),
                     1'($urandom_range(99) < pf), 6'($urandom),
                     1'($urandom_range(99) < pf), 6'($urandom));
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
